ob_seg_display: RTL

- Downstream consumer of the CPU observer sampling port.
- Drives `ob_sel`/`ob_mode_i` from two debounced push-buttons.
- Captures the returned `ob_data_o` word and shows it as 8 hex digits on a multiplexed, active-low 7-segment display.
- Sits at board top level beside `Naive_CPU`; it is the only path by which a user inspects registers, PC, IR and ALU values.

---
 rtl/ob_disp_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/ob_seg_display.sv | 96 +++++++++
 3 files changed

// File: rtl/ob_disp_pkg.sv
// Shared constants and helpers for the observer 7-segment display.
package ob_disp_pkg;

  typedef logic [3:0] nibble_t;

  // Observer mode encodings understood by the CPU observer port.
  localparam logic [1:0] OB_MODE_REG = 2'd0;
  localparam logic [1:0] OB_MODE_PC  = 2'd1;
  localparam logic [1:0] OB_MODE_IR  = 2'd2;
  localparam logic [1:0] OB_MODE_ALU = 2'd3;

  // Active-low gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex7(input nibble_t value);
    return SEG_PATTERNS[value];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// a single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed from the stable level
  // for DEBOUNCE_CYCLES consecutive cycles; pulse on accepted presses only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync_q2;
        cnt_q    <= '0;
        pulse    <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ob_seg_display.sv
// Observer front panel: buttons step the CPU observer select/mode, the
// returned word is latched and scanned out as 8 hex digits.
module ob_seg_display
  import ob_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next_i,
  input  logic        btn_mode_i,
  input  logic [31:0] ob_data_i,
  output logic [4:0]  ob_sel_o,
  output logic [1:0]  ob_mode_o,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o
);

  localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic          next_pulse;
  logic          mode_pulse;
  logic          refresh_q;
  logic [31:0]   latch_q;
  logic [DW-1:0] div_q;
  logic [2:0]    idx_q;
  logic          frame_end;
  nibble_t       cur_nib;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next_i),
    .pulse   (next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode_i),
    .pulse   (mode_pulse)
  );

  assign frame_end = (div_q == DIV_MAX) && (idx_q == 3'd7);
  assign cur_nib   = latch_q[{idx_q, 2'b00} +: 4];

  // Step register select / observer mode on accepted presses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_sel_o  <= 5'd0;
      ob_mode_o <= OB_MODE_REG;
      refresh_q <= 1'b0;
    end else begin
      if (next_pulse) ob_sel_o  <= ob_sel_o + 5'd1;
      if (mode_pulse) ob_mode_o <= ob_mode_o + 2'd1;
      // Observer path is combinational, so the new word is valid next cycle.
      refresh_q <= next_pulse | mode_pulse;
    end
  end

  // Capture the observer word once per frame, or right after a selection change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latch_q <= 32'd0;
    end else if (frame_end || refresh_q) begin
      latch_q <= ob_data_i;
    end
  end

  // Slot divider and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      idx_q <= 3'd0;
    end else if (div_q == DIV_MAX) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Registered anode/segment drive for the current digit; dp held off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_o  <= 8'hFF;
      seg_o <= 8'hFF;
    end else begin
      an_o  <= ~(8'b1 << idx_q);
      seg_o <= {1'b1, hex7(cur_nib)};
    end
  end

endmodule
